// File: rtl/emio_gpio_debounce_if.sv
// Signal bundle between the pad conditioner and its consumers (PS7 EMIO GPIO and fabric).
// The conditioner uses the slave view; the stimulus or pad side uses the master view.
interface emio_gpio_debounce_if #(
   parameter int unsigned WIDTH = 4
);
   logic [WIDTH-1:0] pad_i;
   logic [WIDTH-1:0] event_clr_i;
   logic [WIDTH-1:0] level_o;
   logic [WIDTH-1:0] rise_o;
   logic [WIDTH-1:0] fall_o;
   logic [WIDTH-1:0] event_o;
   logic             irq_o;

   modport slave (
      input  pad_i,
      input  event_clr_i,
      output level_o,
      output rise_o,
      output fall_o,
      output event_o,
      output irq_o
   );

   modport master (
      output pad_i,
      output event_clr_i,
      input  level_o,
      input  rise_o,
      input  fall_o,
      input  event_o,
      input  irq_o
   );
endinterface

// File: rtl/emio_gpio_debounce.sv
// Per-channel synchronizer and debouncer feeding EMIOGPIOI.
// Also provides registered edge pulses, sticky W1C edge events and an OR-ed interrupt.
module emio_gpio_debounce #(
   parameter int unsigned WIDTH         = 4,
   parameter int unsigned STABLE_CYCLES = 50000,
   parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
   input logic                  fclk,
   input logic                  rst_n,
   emio_gpio_debounce_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;
   logic [WIDTH-1:0] level;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] evt;

   logic [WIDTH-1:0] accept;
   logic [WIDTH-1:0] level_next;
   logic [WIDTH-1:0] rise_next;
   logic [WIDTH-1:0] fall_next;
   logic [WIDTH-1:0] evt_next;

   logic [CNT_W-1:0] cnt      [WIDTH];
   logic [CNT_W-1:0] cnt_next [WIDTH];

   // Acceptance clears the counter, so it never needs to wrap.
   always_comb begin
      accept = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         cnt_next[i] = '0;
         if (s2[i] != level[i]) begin
            if (cnt[i] == CNT_LAST) begin
               accept[i] = 1'b1;
            end else begin
               cnt_next[i] = cnt[i] + CNT_W'(1);
            end
         end
      end
      level_next = level ^ accept;
      rise_next  = accept & s2;
      fall_next  = accept & ~s2;
      // A new edge wins over a simultaneous clear.
      evt_next   = (evt & ~bus.event_clr_i) | rise_next | fall_next;
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         s1    <= '0;
         s2    <= '0;
         level <= '0;
         rise  <= '0;
         fall  <= '0;
         evt   <= '0;
         for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         s1    <= bus.pad_i;
         s2    <= s1;
         level <= level_next;
         rise  <= rise_next;
         fall  <= fall_next;
         evt   <= evt_next;
         for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt[i] <= cnt_next[i];
         end
      end
   end

   assign bus.level_o = level;
   assign bus.rise_o  = rise;
   assign bus.fall_o  = fall;
   assign bus.event_o = evt;
   assign bus.irq_o   = |evt;

endmodule

// File: doc/emio_gpio_debounce.md
# emio_gpio_debounce

Multi-channel input conditioner placed directly upstream of the PS7 EMIO GPIO input bus. It synchronizes asynchronous board inputs (buttons, switches, jumpers) into the FCLK domain, debounces each channel independently, and presents clean levels for `EMIOGPIOI`. It also produces single-cycle edge pulses and sticky, software-clearable edge events so fabric logic such as LED counters, and the PS over EMIO outputs, can react to presses without polling.

## Interface
Parameters:
- `WIDTH`, 4: number of independent input channels.
- `STABLE_CYCLES`, 50000: consecutive synchronized cycles a new value must hold before it is accepted. Must be ≥1.
- `CNT_W`, `$clog2(STABLE_CYCLES+1)`: debounce counter width. Derived; do not override.

Ports:
- `fclk`  in  1  clock, PS7 `FCLKCLK[0]`.
- `rst_n`  in  1  reset, asynchronous assert, active-low; all state clears immediately.
- `pad_i`  in  WIDTH  raw asynchronous inputs.
- `event_clr_i`  in  WIDTH  write-1-to-clear for `event_o`, typically driven from `EMIOGPIOO` bits. Synchronous to `fclk`.
- `level_o`  out  WIDTH  debounced level, wired to `EMIOGPIOI`.
- `rise_o`  out  WIDTH  one-cycle pulse when `level_o[i]` goes 0→1.
- `fall_o`  out  WIDTH  one-cycle pulse when `level_o[i]` goes 1→0.
- `event_o`  out  WIDTH  sticky flag, set by either edge on channel i.
- `irq_o`  out  1  OR of `event_o`.

## Operation
- Synchronizer: two flops per channel (`s1`, `s2`), both reset to 0. Only `s2` feeds the rest of the logic.
- Per-channel debounce, all channels identical and independent:
  - When `s2[i] == level_o[i]`, `cnt[i]` ← 0.
  - When `s2[i] != level_o[i]` and `cnt[i] != STABLE_CYCLES-1`, `cnt[i]` ← `cnt[i]+1`.
  - When `s2[i] != level_o[i]` and `cnt[i] == STABLE_CYCLES-1`:
    - `level_o[i]` ← `s2[i]`
    - `cnt[i]` ← 0
    - the matching edge pulse is asserted for exactly that cycle.
- The counter never wraps. It saturates by construction because acceptance resets it.
- A glitch shorter than `STABLE_CYCLES` synchronized cycles resets `cnt` and produces no output change.
- Edge outputs are registered and update on the same edge as `level_o`:
  - `rise_o[i]` = 1 only in the cycle after a 0→1 acceptance.
  - `fall_o[i]` likewise for 1→0.
  - The two are never both high on a channel.
- Event register: `event_o[i]` ← (`event_o[i]` & ~`event_clr_i[i]`) | `rise_o_next[i]` | `fall_o_next[i]`.
  - Set wins over a simultaneous clear.
  - Clearing an already-clear bit has no effect.
  - Other channels are unaffected.
- `irq_o` is the combinational OR of registered `event_o`; it has no extra latency.
- Reset values: `s1`, `s2`, `cnt`, `level_o`, `rise_o`, `fall_o`, `event_o` are all 0, so `irq_o` = 0.
- Reset release with a pad held high is treated as a normal 0→1 transition: `rise_o` pulses and `event_o` is set.

## Timing
- Latency: number the first `fclk` edge that samples a new pad value as edge 1.
  - `level_o`, `rise_o` or `fall_o`, and `event_o` update on edge `STABLE_CYCLES+2`.
  - Worst-case extra cycle from metastability resolution is acceptable.
- `STABLE_CYCLES=1` gives acceptance on edge 3 (synchronizer latency only).
- Edge pulses are exactly 1 cycle wide. Back-to-back accepted edges on one channel are at least `STABLE_CYCLES` cycles apart.
- `event_clr_i` takes effect on the next edge: `event_o` is low the cycle after the clear unless a new edge coincides.
- Asserting `rst_n` low mid-count clears everything immediately. No pulse is emitted on reset entry or exit except as described for a held-high pad.

## Test plan
(`WIDTH=4`, `STABLE_CYCLES=4` throughout.)
- Clean press: hold `pad_i[0]` 0→1 before edge 1.
  - `level_o[0]`=1 and `rise_o[0]`=1 on edge 6 only; `event_o`=4'b0001 from edge 6; `irq_o`=1.
  - Release gives `fall_o[0]` 6 edges later.
- Bounce rejection: `pad_i[1]` high for 3 cycles, low for 1, then high steadily.
  - No change until 4 consecutive synchronized highs; exactly one `rise_o[1]` pulse.
- Clear semantics: set `event_o[2]`, pulse `event_clr_i[2]`.
  - Cleared next edge; `irq_o`=0.
  - Repeat with clear coinciding with a new `fall_o[2]`: `event_o[2]` stays 1.
- Independence: toggle `pad_i[3:0]` with staggered timing.
  - Each channel's `level_o` follows its own `STABLE_CYCLES+2` latency; no cross-channel effects.
- Reset mid-count: `cnt[0]`=2, assert `rst_n` low asynchronously.
  - All outputs are 0 without a clock.
  - After release with pad high, `rise_o[0]` fires on edge 6 after release.
- `STABLE_CYCLES=1` build: a single-cycle pad pulse (sampled once) is accepted.
  - `level_o` is high for exactly 1 cycle at edge 3, with `rise_o` then `fall_o` on consecutive cycles.
